// File: rtl/network_seq_pkg.sv
// Shared definitions for the LSTM network sequencer: default sizes, fixed-point
// word width, FSM state encoding and a width helper.
package network_seq_pkg;

  localparam int DEF_INPUT_SZ       = 2;
  localparam int DEF_HIDDEN_SZ      = 8;
  localparam int DEF_QN             = 6;
  localparam int DEF_QM             = 11;
  localparam int DEF_SEQ_LEN        = 8;
  localparam int DEF_RESET_CYCLES   = 2;
  localparam int DEF_SETTLE_CYCLES  = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  function automatic int calc_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  localparam int BITWIDTH = calc_bitwidth(DEF_QN, DEF_QM);

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  typedef enum logic [2:0] {
    SEQ_RST,
    IDLE,
    ISSUE,
    WAIT,
    SETTLE,
    DRAIN
  } seq_state_e;

endpackage

// File: rtl/network_vec_serializer.sv
// Parallel-in serial-out register for the network hidden vector: loads all words
// at once and hands them out word 0 first over a valid/ready stream.
module network_vec_serializer import network_seq_pkg::*; #(
  parameter int WORDS = DEF_HIDDEN_SZ,
  parameter int WIDTH = BITWIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [WORDS*WIDTH-1:0] vec_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   last_o,
  output logic                   done_o
);

  localparam int IDX_W = clog2(WORDS);

  logic [WIDTH-1:0] vec_words[WORDS];
  logic [WIDTH-1:0] words_q[WORDS];
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             fire;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_unpack
      assign vec_words[gi] = vec_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign fire = valid_q & ready_i;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < WORDS; i++) words_q[i] <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      idx_q   <= '0;
      for (int i = 0; i < WORDS; i++) words_q[i] <= vec_words[i];
    end else if (fire) begin
      // Word 0 is always the one presented; shifting only on accept keeps it stable under stall.
      for (int i = 0; i < WORDS - 1; i++) words_q[i] <= words_q[i+1];
      if (idx_q == IDX_W'(WORDS - 1)) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = words_q[0];
  assign last_o  = valid_q & (idx_q == IDX_W'(WORDS - 1));
  assign done_o  = fire & last_o;

endmodule

// File: rtl/network_sequencer.sv
// Drives the LSTM network sample handshake: accepts input vectors, pulses newSample,
// captures the hidden vector after dataReady and streams it out. Define SEQ_TIMEOUT_EN for the dataReady watchdog.
module network_sequencer import network_seq_pkg::*; #(
  parameter int INPUT_SZ       = DEF_INPUT_SZ,
  parameter int HIDDEN_SZ      = DEF_HIDDEN_SZ,
  parameter int QN             = DEF_QN,
  parameter int QM             = DEF_QM,
  parameter int SEQ_LEN        = DEF_SEQ_LEN,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int BW            = calc_bitwidth(QN, QM)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_SZ*BW-1:0]  in_data,
  output logic [INPUT_SZ*BW-1:0]  net_inputVec,
  output logic                    net_newSample,
  output logic                    net_reset,
  input  logic                    net_dataReady,
  input  logic [HIDDEN_SZ*BW-1:0] net_outputVec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BW-1:0]           out_data,
  output logic                    out_last,
  output logic                    out_seq_end,
  output logic                    seq_done,
  output logic                    err_timeout
);

  localparam int STEP_W = clog2(SEQ_LEN);
  localparam int CNT_W  = clog2((RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES);

  seq_state_e              state_q;
  logic [STEP_W-1:0]       step_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    dr_q;
  logic                    net_reset_q;
  logic                    in_ready_q;
  logic                    new_sample_q;
  logic                    seq_done_q;
  logic [INPUT_SZ*BW-1:0]  input_vec_q;

  logic dr_rise;
  logic ser_load;
  logic ser_last;
  logic ser_done;

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog_q;
  logic            err_timeout_q;
`endif

  assign dr_rise  = net_dataReady & ~dr_q;
  assign ser_load = (state_q == SETTLE) && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= SEQ_RST;
      step_q       <= '0;
      cnt_q        <= '0;
      dr_q         <= 1'b0;
      net_reset_q  <= 1'b1;
      in_ready_q   <= 1'b0;
      new_sample_q <= 1'b0;
      seq_done_q   <= 1'b0;
      input_vec_q  <= '0;
`ifdef SEQ_TIMEOUT_EN
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      dr_q         <= net_dataReady;
      new_sample_q <= 1'b0;
      seq_done_q   <= 1'b0;
      case (state_q)
        SEQ_RST: begin
          if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            net_reset_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (in_valid && in_ready_q) begin
            input_vec_q  <= in_data;
            in_ready_q   <= 1'b0;
            new_sample_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef SEQ_TIMEOUT_EN
          wdog_q <= '0;
`endif
        end
        WAIT: begin
          // dr_q is sampled in every state, so a level already high here is not a rise.
          if (dr_rise) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err_timeout_q <= 1'b1;
            step_q        <= '0;
            cnt_q         <= '0;
            net_reset_q   <= 1'b1;
            state_q       <= SEQ_RST;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        SETTLE: begin
          if (ser_load) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (ser_done) begin
            if (step_q == STEP_W'(SEQ_LEN - 1)) begin
              step_q      <= '0;
              seq_done_q  <= 1'b1;
              cnt_q       <= '0;
              net_reset_q <= 1'b1;
              state_q     <= SEQ_RST;
            end else begin
              step_q     <= step_q + 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= SEQ_RST;
      endcase
    end
  end

  network_vec_serializer #(
    .WORDS (HIDDEN_SZ),
    .WIDTH (BW)
  ) u_serializer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (ser_load),
    .vec_i   (net_outputVec),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (out_data),
    .last_o  (ser_last),
    .done_o  (ser_done)
  );

  assign in_ready      = in_ready_q;
  assign net_inputVec  = input_vec_q;
  assign net_newSample = new_sample_q;
  assign net_reset     = net_reset_q;
  assign out_last      = ser_last;
  assign out_seq_end   = ser_last & (step_q == STEP_W'(SEQ_LEN - 1));
  assign seq_done      = seq_done_q;

`ifdef SEQ_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  // No watchdog is built; the parameter only keeps the interface identical in both builds.
  assign err_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench for network_sequencer: each expected output word is queued when the
// model network raises dataReady and compared as the word is accepted downstream.
module tb_network_sequencer;

  localparam int BW  = 18;
  localparam int ISZ = 2;
  localparam int HSZ = 8;
  localparam int SEQ = 8;

  logic               clock;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [ISZ*BW-1:0]  in_data;
  logic [ISZ*BW-1:0]  net_inputVec;
  logic               net_newSample;
  logic               net_reset;
  logic               net_dataReady;
  logic [HSZ*BW-1:0]  net_outputVec;
  logic               out_valid;
  logic               out_ready;
  logic [BW-1:0]      out_data;
  logic               out_last;
  logic               out_seq_end;
  logic               seq_done;
  logic               err_timeout;

  int checks;
  int errors;
  int step_no;
  int tag;
  logic [BW+1:0] sb[$];

  network_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .net_inputVec  (net_inputVec),
    .net_newSample (net_newSample),
    .net_reset     (net_reset),
    .net_dataReady (net_dataReady),
    .net_outputVec (net_outputVec),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_seq_end   (out_seq_end),
    .seq_done      (seq_done),
    .err_timeout   (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model network result: word j of step tag t; tag 0 gives 1..8.
  function automatic logic [HSZ*BW-1:0] mk_vec(input int t);
    logic [HSZ*BW-1:0] v;
    logic [BW-1:0]     w;
    v = '0;
    for (int j = 0; j < HSZ; j++) begin
      w = BW'(j + 1 + t * 16);
      if (t % 2 == 1) w = w ^ 18'h24000;
      v[j*BW +: BW] = w;
    end
    return v;
  endfunction

  task automatic release_reset(input string name);
    int n;
    reset = 1'b1;
    n = 0;
    while (net_reset === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: net_reset cycles=%0d in_ready=%b, want 2 and 1", name, n, in_ready);
    end
  endtask

  task automatic accept_sample(input logic [ISZ*BW-1:0] vec);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    in_valid = 1'b1;
    in_data  = vec;
    tick();
    in_valid = 1'b0;
    in_data  = ~vec;
    checks++;
    if (net_newSample !== 1'b1 || net_inputVec !== vec || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: newSample=%b vec=%h in_ready=%b, want 1 %h 0", net_newSample, net_inputVec, in_ready, vec);
    end
    tick();
    checks++;
    if (net_newSample !== 1'b0 || in_ready !== 1'b0 || net_inputVec !== vec) begin
      errors++;
      $display("FAIL issue_pulse: newSample=%b in_ready=%b vec=%h, want 0 0 %h", net_newSample, in_ready, net_inputVec, vec);
    end
  endtask

  task automatic raise_ready(input int t);
    logic [HSZ*BW-1:0] v;
    int n;
    v = mk_vec(t);
    net_outputVec = v;
    net_dataReady = 1'b1;
    for (int j = 0; j < HSZ; j++)
      sb.push_back({v[j*BW +: BW], (j == HSZ - 1), (j == HSZ - 1) && (step_no == SEQ - 1)});
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL dr_latency: first out_valid after %0d cycles, want 3", n);
    end
    net_dataReady = 1'b0;
    net_outputVec = ~v;
  endtask

  task automatic drain(input bit toggle, input int max_words);
    logic          rdy;
    logic [BW:0]   held;
    logic [BW+1:0] exp;
    int            taken;
    taken = 0;
    held  = '0;
    for (int c = 0; c < 200 && sb.size() > 0 && taken < max_words; c++) begin
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      out_ready = rdy;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_drain: in_ready=%b, want 0", in_ready);
      end
      if (rdy) begin
        exp = sb.pop_front();
        taken++;
        checks++;
        if (out_valid !== 1'b1 || {out_data, out_last, out_seq_end} !== exp) begin
          errors++;
          $display("FAIL word: got v=%b d=%h last=%b end=%b, want v=1 d=%h last=%b end=%b",
                   out_valid, out_data, out_last, out_seq_end, exp[BW+1:2], exp[1], exp[0]);
        end
      end else begin
        held = {out_valid, out_data};
      end
      tick();
      if (!rdy) begin
        checks++;
        if ({out_valid, out_data} !== held) begin
          errors++;
          $display("FAIL stall: got v=%b d=%h, want v=%b d=%h", out_valid, out_data, held[BW], held[BW-1:0]);
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (taken != max_words) begin
      errors++;
      $display("FAIL drain_count: took %0d words, want %0d", taken, max_words);
    end
  endtask

  task automatic finish_step();
    if (step_no == SEQ - 1) begin
      checks++;
      if (seq_done !== 1'b1 || net_reset !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_done_pulse: seq_done=%b net_reset=%b out_valid=%b, want 1 1 0", seq_done, net_reset, out_valid);
      end
      tick();
      checks++;
      if (seq_done !== 1'b0 || net_reset !== 1'b1) begin
        errors++;
        $display("FAIL seq_done_width: seq_done=%b net_reset=%b, want 0 1", seq_done, net_reset);
      end
      tick();
      checks++;
      if (net_reset !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL seq_reset_len: net_reset=%b in_ready=%b, want 0 1", net_reset, in_ready);
      end
      step_no = 0;
    end else begin
      checks++;
      if (seq_done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || net_reset !== 1'b0) begin
        errors++;
        $display("FAIL step_end: seq_done=%b in_ready=%b out_valid=%b net_reset=%b, want 0 1 0 0",
                 seq_done, in_ready, out_valid, net_reset);
      end
      step_no++;
    end
  endtask

  task automatic run_step(input logic [ISZ*BW-1:0] vec, input bit toggle);
    accept_sample(vec);
    raise_ready(tag);
    tag++;
    drain(toggle, HSZ);
    finish_step();
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    net_dataReady = 1'b0;
    net_outputVec = '0;
    out_ready     = 1'b0;
    repeat (3) tick();
    checks++;
    if ({net_reset, in_ready, out_valid, net_newSample, seq_done, err_timeout} !== 6'b100000 || net_inputVec !== '0) begin
      errors++;
      $display("FAIL reset_state: rst/rdy/vld/ns/done/err=%b vec=%h, want 100000 0",
               {net_reset, in_ready, out_valid, net_newSample, seq_done, err_timeout}, net_inputVec);
    end
    release_reset("reset_release");
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (net_newSample !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_quiet: newSample=%b in_ready=%b, want 0 1", net_newSample, in_ready);
      end
    end
  endtask

  task automatic test_single_step();
    run_step({18'h00800, 18'h3F800}, 1'b0);
  endtask

  task automatic test_backpressure();
    run_step(36'h1_2345_6789, 1'b1);
  endtask

  task automatic test_full_sequence();
    logic [ISZ*BW-1:0] r;
    for (int s = 2; s < SEQ; s++) begin
      r = ISZ*BW'({$urandom(), $urandom()});
      run_step(r, s[0]);
    end
  endtask

  task automatic test_dr_held_and_reset();
    logic [ISZ*BW-1:0] vec;
    vec = 36'hA_BCDE_F012;
    net_outputVec = ~mk_vec(tag);
    net_dataReady = 1'b1;
    accept_sample(vec);
    in_valid = 1'b1;
    repeat (5) tick();
    checks++;
    if (out_valid !== 1'b0 || net_newSample !== 1'b0 || net_inputVec !== vec) begin
      errors++;
      $display("FAIL dr_held: out_valid=%b newSample=%b vec=%h, want 0 0 %h", out_valid, net_newSample, net_inputVec, vec);
    end
    in_valid = 1'b0;
    net_dataReady = 1'b0;
    tick();
    raise_ready(tag);
    tag++;
    drain(1'b0, 3);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain: out_valid=%b, want 1", out_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || net_reset !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: out_valid=%b net_reset=%b in_ready=%b, want 0 1 0", out_valid, net_reset, in_ready);
    end
    sb.delete();
    step_no = 0;
    tick();
    tick();
    release_reset("abort_release");
  endtask

  task automatic test_timeout();
    accept_sample(36'h0_0F0F_0F0F);
`ifdef SEQ_TIMEOUT_EN
    repeat (15) tick();
    checks++;
    if (err_timeout !== 1'b0 || net_reset !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err=%b net_reset=%b, want 0 0", err_timeout, net_reset);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || net_reset !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: err=%b net_reset=%b in_ready=%b, want 1 1 0", err_timeout, net_reset, in_ready);
    end
    tick();
    tick();
    checks++;
    if (err_timeout !== 1'b1 || net_reset !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: err=%b net_reset=%b in_ready=%b out_valid=%b, want 1 0 1 0",
               err_timeout, net_reset, in_ready, out_valid);
    end
`else
    repeat (40) tick();
    checks++;
    if (err_timeout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || net_reset !== 1'b0) begin
      errors++;
      $display("FAIL wait_blocks: err=%b in_ready=%b out_valid=%b net_reset=%b, want 0 0 0 0",
               err_timeout, in_ready, out_valid, net_reset);
    end
`endif
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    tag     = 0;
    test_reset();
    test_single_step();
    test_backpressure();
    test_full_sequence();
    test_dr_held_and_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
